// File: rtl/dtt_scheduler.sv
// -----------------------------------------------------------------------------
// dtt_scheduler
//
// Shares one countdown (DTT) spike encoder among NUM_REQ requesters. In IDLE
// one requester is granted in round-robin order. Its delay value is loaded and
// counted down, and a single spike tagged with the requester id is emitted
// when the count expires. A zero value is accepted but discarded, and this is
// flagged on drop.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RES        synchronous reset, active-high
//   req_valid  per-requester value valid
//   req_value  flattened values; requester i at [i*DTT_WIDTH +: DTT_WIDTH]
//   req_ready  one-hot grant (IDLE only); transfer on valid & ready
//   flush      synchronous abort of the active countdown
//   spike      one-cycle spike pulse
//   spike_id   owner of the current spike; 0 when spike is low
//   busy       high while counting
//   drop       one-cycle pulse after a zero value was accepted
// -----------------------------------------------------------------------------
module dtt_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DTT_WIDTH = 5,
    parameter int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           CLK,
    input  logic                           RES,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DTT_WIDTH-1:0]   req_value,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           flush,
    output logic                           spike,
    output logic [ID_W-1:0]                spike_id,
    output logic                           busy,
    output logic                           drop
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    localparam logic [ID_W-1:0]      LAST_ID = ID_W'(NUM_REQ - 1);
    localparam logic [DTT_WIDTH-1:0] ONE     = DTT_WIDTH'(1);

    logic [0:0]           state;
    logic [DTT_WIDTH-1:0] count;
    logic [ID_W-1:0]      owner;
    logic [ID_W-1:0]      last_grant;
    logic                 drop_r;

    logic                 found;
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_id;
    logic [DTT_WIDTH-1:0] gnt_value;
    logic                 xfer;

    // Round-robin search split into two ascending passes: the first covers
    // last_grant+1 .. NUM_REQ-1 and the second wraps to 0 .. last_grant. This
    // avoids a modulo on a variable index.
    always_comb begin
        found     = 1'b0;
        gnt       = '0;
        gnt_id    = '0;
        gnt_value = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i > 32'(last_grant))) begin
                found     = 1'b1;
                gnt[i]    = 1'b1;
                gnt_id    = ID_W'(i);
                gnt_value = req_value[i*DTT_WIDTH +: DTT_WIDTH];
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid[i] && (i <= 32'(last_grant))) begin
                found     = 1'b1;
                gnt[i]    = 1'b1;
                gnt_id    = ID_W'(i);
                gnt_value = req_value[i*DTT_WIDTH +: DTT_WIDTH];
            end
        end
    end

    assign xfer      = (state == ST_IDLE) && found;
    assign req_ready = (state == ST_IDLE) ? gnt : '0;
    assign busy      = (state == ST_COUNT);
    assign spike     = (state == ST_COUNT) && (count == ONE);
    assign spike_id  = spike ? owner : '0;
    assign drop      = drop_r;

    always_ff @(posedge CLK) begin
        if (RES) begin
            state      <= ST_IDLE;
            count      <= '0;
            owner      <= '0;
            last_grant <= LAST_ID;
            drop_r     <= 1'b0;
        end else begin
            drop_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        last_grant <= gnt_id;
                        owner      <= gnt_id;
                        if (gnt_value != '0) begin
                            count <= gnt_value;
                            state <= ST_COUNT;
                        end else begin
                            drop_r <= 1'b1;
                        end
                    end
                end
                ST_COUNT: begin
                    // A flush on the count==1 cycle still lets that cycle's
                    // spike show, because spike is decoded from the registered
                    // count. The <= guard keeps the counter from wrapping.
                    if (flush || (count <= ONE)) begin
                        count <= '0;
                        state <= ST_IDLE;
                    end else begin
                        count <= count - ONE;
                    end
                end
                default: begin
                    count <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtt_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dtt_scheduler
//
// Directed bench for dtt_scheduler with NUM_REQ=4 and DTT_WIDTH=5. A table of
// per-cycle records covers the single-grant, round-robin, wrap-priority and
// zero-value cases. Hand-written sequences cover flush and mid-count reset.
// Inputs are driven 1 time unit after the rising edge. Outputs are compared
// 3 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_dtt_scheduler;

    logic        CLK = 1'b0;
    logic        RES;
    logic [3:0]  req_valid;
    logic [19:0] req_value;
    logic [3:0]  req_ready;
    logic        flush;
    logic        spike;
    logic [1:0]  spike_id;
    logic        busy;
    logic        drop;

    int tests_run = 0;
    int tests_failed = 0;

    dtt_scheduler #(.NUM_REQ(4), .DTT_WIDTH(5)) dut (
        .CLK       (CLK),
        .RES       (RES),
        .req_valid (req_valid),
        .req_value (req_value),
        .req_ready (req_ready),
        .flush     (flush),
        .spike     (spike),
        .spike_id  (spike_id),
        .busy      (busy),
        .drop      (drop)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [19:0] values;
        logic        fl;
        logic [3:0]  ready;
        logic        spk;
        logic [1:0]  sid;
        logic        bsy;
        logic        drp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [19:0] vals(input int v0, input int v1, input int v2, input int v3);
        return {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] valid, input logic [19:0] values,
                                input logic fl, input logic [3:0] ready, input logic spk,
                                input logic [1:0] sid, input logic bsy, input logic drp);
        vec_t v;
        v.rst = rst; v.valid = valid; v.values = values; v.fl = fl;
        v.ready = ready; v.spk = spk; v.sid = sid; v.bsy = bsy; v.drp = drp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] rdy, input logic spk,
                           input logic [1:0] sid, input logic bsy, input logic drp);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, ".spike"},     32'(spike),     32'(spk));
        chk({tag, ".spike_id"},  32'(spike_id),  32'(sid));
        chk({tag, ".busy"},      32'(busy),      32'(bsy));
        chk({tag, ".drop"},      32'(drop),      32'(drp));
    endtask

    task automatic drive(input logic rst, input logic [3:0] valid, input logic [19:0] values, input logic fl);
        RES = rst; req_valid = valid; req_value = values; flush = fl;
        #2;
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // A: reset, then requester 0 with value 3
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0001, vals(3,0,0,0), 0, 4'b0001, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 1, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 0, 0, 0, 0));
        // B: reset, then all four valid with value 1, so grants go 0,1,2,3,0
        tbl.push_back(mk(1, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 0, 0, 0, 0));
        for (int r = 0; r < 5; r++) begin
            tbl.push_back(mk(0, 4'b1111, vals(1,1,1,1), 0, 4'(1 << (r % 4)), 0, 0, 0, 0));
            tbl.push_back(mk(0, 4'b1111, vals(1,1,1,1), 0, 4'b0000, 1, 2'(r % 4), 1, 0));
        end
        // C: last grant is 1, so with 1010 valid requester 3 goes before 1
        tbl.push_back(mk(0, 4'b0010, vals(0,1,0,0), 0, 4'b0010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'b1010, vals(0,2,0,2), 0, 4'b1000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, vals(0,2,0,0), 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0010, vals(0,2,0,0), 0, 4'b0000, 1, 3, 1, 0));
        tbl.push_back(mk(0, 4'b0010, vals(0,2,0,0), 0, 4'b0010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 1, 1, 1, 0));
        // D: zero value dropped; the next grant is made while drop is high
        tbl.push_back(mk(0, 4'b0001, vals(0,0,0,0), 0, 4'b0001, 0, 0, 0, 0));
        tbl.push_back(mk(0, 4'b0010, vals(0,1,0,0), 0, 4'b0010, 0, 0, 0, 1));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 1, 1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, vals(0,0,0,0), 0, 4'b0000, 0, 0, 0, 0));

        drive(1, 4'b0000, '0, 0);
        tick; tick;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].valid, tbl[i].values, tbl[i].fl);
            chk_out($sformatf("vec%0d", i), tbl[i].ready, tbl[i].spk, tbl[i].sid, tbl[i].bsy, tbl[i].drp);
            tick;
        end

        // E: value 31 on requester 2 (last grant is 1), flushed at count 10
        drive(0, 4'b0100, vals(0,0,31,0), 0);
        chk_out("flush10.grant", 4'b0100, 0, 0, 0, 0);
        tick;
        for (int c = 31; c > 10; c--) begin
            drive(0, 4'b0000, '0, 0);
            chk_out($sformatf("flush10.cnt%0d", c), 4'b0000, 0, 0, 1, 0);
            tick;
        end
        drive(0, 4'b0000, '0, 1);
        chk_out("flush10.at", 4'b0000, 0, 0, 1, 0);
        tick;
        for (int k = 0; k < 10; k++) begin
            drive(0, 4'b0000, '0, 0);
            chk_out($sformatf("flush10.after%0d", k), 4'b0000, 0, 0, 0, 0);
            tick;
        end

        // F: flush on the count==1 cycle still shows that cycle's spike
        drive(0, 4'b1000, vals(0,0,0,2), 0);
        chk_out("flush1.grant", 4'b1000, 0, 0, 0, 0);
        tick;
        drive(0, 4'b0000, '0, 0);
        chk_out("flush1.cnt2", 4'b0000, 0, 0, 1, 0);
        tick;
        drive(0, 4'b0000, '0, 1);
        chk_out("flush1.at", 4'b0000, 1, 3, 1, 0);
        tick;
        drive(0, 4'b0000, '0, 0);
        chk_out("flush1.after", 4'b0000, 0, 0, 0, 0);
        tick;

        // G: reset at count 5; afterwards requester 0 beats requester 2
        drive(0, 4'b0001, vals(7,0,0,0), 0);
        chk_out("rst.grant", 4'b0001, 0, 0, 0, 0);
        tick;
        drive(0, 4'b0000, '0, 0);
        chk_out("rst.cnt7", 4'b0000, 0, 0, 1, 0);
        tick;
        chk_out("rst.cnt6", 4'b0000, 0, 0, 1, 0);
        tick;
        drive(1, 4'b0000, '0, 1);
        chk_out("rst.cnt5", 4'b0000, 0, 0, 1, 0);
        tick;
        drive(0, 4'b0000, '0, 0);
        chk_out("rst.after", 4'b0000, 0, 0, 0, 0);
        tick;
        drive(0, 4'b0101, vals(1,0,1,0), 0);
        chk_out("rst.prio", 4'b0001, 0, 0, 0, 0);
        tick;
        drive(0, 4'b0100, vals(0,0,1,0), 0);
        chk_out("rst.spike0", 4'b0000, 1, 0, 1, 0);
        tick;
        chk_out("rst.next2", 4'b0100, 0, 0, 0, 0);
        tick;
        drive(0, 4'b0000, '0, 0);
        chk_out("rst.spike2", 4'b0000, 1, 2, 1, 0);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
